// File: rtl/seg7_scan_driver_pkg.sv
// Shared definitions for the 7-segment scan driver.
// Segment patterns are 7 bits ordered {g, fp, e, d, c, b, a}, active low
// (0 = segment lit). Also holds the converter state encoding, the digit
// slot indices and a BCD-digit-to-pattern helper.
package seg7_scan_driver_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } conv_state_t;

    localparam logic [1:0] DIG_UNITS    = 2'd0;
    localparam logic [1:0] DIG_TENS     = 2'd1;
    localparam logic [1:0] DIG_HUNDREDS = 2'd2;

    // Decimal digit to active-low segment pattern; non-decimal codes blank.
    function automatic logic [6:0] seg_of_digit(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Host-side load handshake of the scan driver.
//   load  : single-cycle strobe, captures value when busy=0
//   value : 10-bit binary value to display
//   busy  : conversion in progress
// master = value producer (CPU side), slave = the display driver.
interface seg7_scan_driver_if;
    logic       load;
    logic [9:0] value;
    logic       busy;

    modport master (output load, output value, input busy);
    modport slave  (input load, input value, output busy);
endinterface

// File: rtl/seg7_scan_driver_bin2bcd_seq.sv
// Sequential double-dabble: 10-bit binary to three BCD digits, one bit per
// clock, MSB first.
// Ports: clock, reset_n (async, active low), start (accepted only in IDLE),
//        bin_in[9:0], busy, done (high during the COMMIT cycle, when the
//        digit outputs are final), hundreds/tens/units[3:0], overflow
//        (captured value > 999).
module bin2bcd_seq
    import seg7_scan_driver_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic [9:0] bin_in,
    output logic       busy,
    output logic       done,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       overflow
);

    conv_state_t state_r;
    conv_state_t state_nxt;
    logic [9:0]  bin_r;
    logic [11:0] bcd_r;
    logic [3:0]  cnt_r;
    logic        ovf_r;
    logic [11:0] bcd_adj_s;
    logic [21:0] shifted_s;

    // Nibble correction so the following left shift carries decimally.
    function automatic logic [3:0] add3(input logic [3:0] nib);
        logic [3:0] res;
        if (nib >= 4'd5) begin
            res = nib + 4'd3;
        end else begin
            res = nib;
        end
        return res;
    endfunction

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state logic; cnt_r==0 marks the 10th shift.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_SHIFT;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == 4'd0) begin
                    state_nxt = ST_COMMIT;
                end else begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_COMMIT: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_r)
            ST_IDLE:   begin busy = 1'b0; done = 1'b0; end
            ST_SHIFT:  begin busy = 1'b1; done = 1'b0; end
            ST_COMMIT: begin busy = 1'b1; done = 1'b1; end
            default:   begin busy = 1'b0; done = 1'b0; end
        endcase
    end

    // Add-3 correction then combined {bcd, bin} left shift.
    always_comb begin
        bcd_adj_s = {add3(bcd_r[11:8]), add3(bcd_r[7:4]), add3(bcd_r[3:0])};
        shifted_s = {bcd_adj_s[10:0], bin_r, 1'b0};
    end

    // Datapath: capture on start, shift while in SHIFT, hold otherwise.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bin_r <= 10'd0;
            bcd_r <= 12'd0;
            cnt_r <= 4'd0;
            ovf_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && start) begin
            bin_r <= bin_in;
            bcd_r <= 12'd0;
            cnt_r <= 4'd9;
            ovf_r <= (bin_in > 10'd999);
        end else if (state_r == ST_SHIFT) begin
            bcd_r <= shifted_s[21:10];
            bin_r <= shifted_s[9:0];
            if (cnt_r != 4'd0) begin
                cnt_r <= cnt_r - 4'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end else begin
            bin_r <= bin_r;
            bcd_r <= bcd_r;
            cnt_r <= cnt_r;
            ovf_r <= ovf_r;
        end
    end

    assign hundreds = bcd_r[11:8];
    assign tens     = bcd_r[7:4];
    assign units    = bcd_r[3:0];
    assign overflow = ovf_r;

endmodule

// File: rtl/seg7_scan_driver.sv
// 3-digit, active-low, time-multiplexed 7-segment display driver.
// A loaded 10-bit value is converted to BCD by bin2bcd_seq; the displayed
// digits only change when a conversion commits. A prescaler steps the scan
// index every SCAN_DIV clocks (0 = AN0/units, 1 = AN1/tens, 2 = AN2/hundreds).
// Ports: clock, reset_n (async, active low), enable (0 = all anodes off),
//        host (load/value/busy handshake, slave side),
//        AN0..AN2 anodes, a,b,c,d,e,fp,g segments (fp = segment f), dp;
//        all display outputs active low and registered, dp held high.
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 enable,
    seg7_scan_driver_if.slave    host,
    output logic                 AN0,
    output logic                 AN1,
    output logic                 AN2,
    output logic                 a,
    output logic                 b,
    output logic                 c,
    output logic                 d,
    output logic                 e,
    output logic                 fp,
    output logic                 g,
    output logic                 dp
);

    localparam int             PW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(SCAN_DIV - 1);

    logic          conv_busy_s;
    logic          conv_done_s;
    logic [3:0]    conv_h_s, conv_t_s, conv_u_s;
    logic          conv_ovf_s;

    logic [3:0]    hund_r, tens_r, units_r;
    logic          ovf_r;
    logic [3:0]    eff_h_s, eff_t_s, eff_u_s;
    logic          eff_ovf_s;

    logic [PW-1:0] pre_r, pre_nxt;
    logic [1:0]    idx_r, idx_nxt;
    logic [2:0]    an_r, an_nxt;
    logic [6:0]    seg_r, seg_nxt;
    logic [6:0]    pat_s;

    bin2bcd_seq u_conv (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (host.load),
        .bin_in   (host.value),
        .busy     (conv_busy_s),
        .done     (conv_done_s),
        .hundreds (conv_h_s),
        .tens     (conv_t_s),
        .units    (conv_u_s),
        .overflow (conv_ovf_s)
    );

    assign host.busy = conv_busy_s;

    // Committed display digits, written only in the converter's COMMIT cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hund_r  <= 4'd0;
            tens_r  <= 4'd0;
            units_r <= 4'd0;
            ovf_r   <= 1'b0;
        end else if (conv_done_s) begin
            hund_r  <= conv_h_s;
            tens_r  <= conv_t_s;
            units_r <= conv_u_s;
            ovf_r   <= conv_ovf_s;
        end else begin
            hund_r  <= hund_r;
            tens_r  <= tens_r;
            units_r <= units_r;
            ovf_r   <= ovf_r;
        end
    end

    // Digits seen by the output register: forward the committing value so
    // the new digits appear on the very edge that ends COMMIT.
    always_comb begin
        if (conv_done_s) begin
            eff_h_s   = conv_h_s;
            eff_t_s   = conv_t_s;
            eff_u_s   = conv_u_s;
            eff_ovf_s = conv_ovf_s;
        end else begin
            eff_h_s   = hund_r;
            eff_t_s   = tens_r;
            eff_u_s   = units_r;
            eff_ovf_s = ovf_r;
        end
    end

    // Prescaler and scan index next values; both parked at 0 while disabled.
    always_comb begin
        pre_nxt = pre_r;
        idx_nxt = idx_r;
        if (!enable) begin
            pre_nxt = '0;
            idx_nxt = DIG_UNITS;
        end else if (pre_r == PRE_LAST) begin
            pre_nxt = '0;
            if (idx_r == DIG_HUNDREDS) begin
                idx_nxt = DIG_UNITS;
            end else begin
                idx_nxt = idx_r + 2'd1;
            end
        end else begin
            pre_nxt = pre_r + PW'(1);
            idx_nxt = idx_r;
        end
    end

    // Segment pattern for the slot being selected, with overflow dashes and
    // leading-zero blanking.
    always_comb begin
        pat_s = SEG_BLANK;
        case (idx_nxt)
            DIG_UNITS: begin
                if (eff_ovf_s) begin
                    pat_s = SEG_DASH;
                end else begin
                    pat_s = seg_of_digit(eff_u_s);
                end
            end
            DIG_TENS: begin
                if (eff_ovf_s) begin
                    pat_s = SEG_DASH;
                end else if (BLANK_LZ && (eff_h_s == 4'd0) && (eff_t_s == 4'd0)) begin
                    pat_s = SEG_BLANK;
                end else begin
                    pat_s = seg_of_digit(eff_t_s);
                end
            end
            DIG_HUNDREDS: begin
                if (eff_ovf_s) begin
                    pat_s = SEG_DASH;
                end else if (BLANK_LZ && (eff_h_s == 4'd0)) begin
                    pat_s = SEG_BLANK;
                end else begin
                    pat_s = seg_of_digit(eff_h_s);
                end
            end
            default: pat_s = SEG_BLANK;
        endcase
    end

    // Anode/segment next values; everything dark while disabled.
    always_comb begin
        an_nxt  = 3'b111;
        seg_nxt = SEG_BLANK;
        if (enable) begin
            an_nxt  = ~(3'b001 << idx_nxt);
            seg_nxt = pat_s;
        end else begin
            an_nxt  = 3'b111;
            seg_nxt = SEG_BLANK;
        end
    end

    // Scan state and registered display outputs, updated together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pre_r <= '0;
            idx_r <= DIG_UNITS;
            an_r  <= 3'b111;
            seg_r <= SEG_BLANK;
        end else begin
            pre_r <= pre_nxt;
            idx_r <= idx_nxt;
            an_r  <= an_nxt;
            seg_r <= seg_nxt;
        end
    end

    assign AN0 = an_r[0];
    assign AN1 = an_r[1];
    assign AN2 = an_r[2];
    assign a   = seg_r[0];
    assign b   = seg_r[1];
    assign c   = seg_r[2];
    assign d   = seg_r[3];
    assign e   = seg_r[4];
    assign fp  = seg_r[5];
    assign g   = seg_r[6];
    assign dp  = 1'b1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (SCAN_DIV=4, BLANK_LZ=1).
// A value-level model (displayed number, busy countdown, enabled-cycle count)
// predicts the display every cycle; literal checks pin specific patterns.
module tb_seg7_scan_driver;

    localparam int DIV = 4;

    logic clk;
    logic rst_n;
    logic en;
    logic an0, an1, an2, sa, sb, sc, sd, se, sf, sg, sdp;

    int checks = 0;
    int errors = 0;

    seg7_scan_driver_if hif ();

    seg7_scan_driver #(.SCAN_DIV(DIV), .BLANK_LZ(1'b1)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .enable  (en),
        .host    (hif),
        .AN0     (an0),
        .AN1     (an1),
        .AN2     (an2),
        .a       (sa),
        .b       (sb),
        .c       (sc),
        .d       (sd),
        .e       (se),
        .fp      (sf),
        .g       (sg),
        .dp      (sdp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [6:0] dut_seg = {sg, sf, se, sd, sc, sb, sa};
    wire [2:0] dut_an  = {an2, an1, an0};

    // Lit segments of each decimal digit, by letter.
    string digit_lit [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                              "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

    function automatic logic [6:0] lit_mask(input string s);
        logic [6:0] m;
        m = 7'h7F;
        for (int i = 0; i < s.len(); i++) begin
            m[int'(s[i]) - 97] = 1'b0;
        end
        return m;
    endfunction

    // Pattern a slot must show for a displayed number v.
    function automatic logic [6:0] slot_pattern(input int slot, input int v);
        if (v > 999) return lit_mask("g");
        case (slot)
            0:       return lit_mask(digit_lit[v % 10]);
            1:       return (v < 10)  ? 7'h7F : lit_mask(digit_lit[(v / 10) % 10]);
            default: return (v < 100) ? 7'h7F : lit_mask(digit_lit[v / 100]);
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state.
    int disp_val, cap_val, busy_cnt, en_cycles;
    bit out_en;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_val  <= 0;
            cap_val   <= 0;
            busy_cnt  <= 0;
            en_cycles <= 0;
            out_en    <= 1'b0;
        end else begin
            if (busy_cnt == 0) begin
                if (hif.load) begin
                    busy_cnt <= 11;
                    cap_val  <= int'(hif.value);
                end
            end else begin
                busy_cnt <= busy_cnt - 1;
                if (busy_cnt == 1) disp_val <= cap_val;
            end
            out_en <= en;
            if (en) en_cycles <= en_cycles + 1;
            else    en_cycles <= 0;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        int slot;
        logic [2:0] exp_an;
        slot   = (en_cycles / DIV) % 3;
        exp_an = 3'b111;
        if (out_en) exp_an[slot] = 1'b0;
        check("anodes", {29'd0, dut_an}, {29'd0, exp_an});
        check("segments", {25'd0, dut_seg},
              {25'd0, out_en ? slot_pattern(slot, disp_val) : 7'h7F});
        check("busy", {31'd0, hif.busy}, {31'd0, busy_cnt != 0});
        check("dp", {31'd0, sdp}, 32'd1);
    end

    task automatic do_load(input logic [9:0] v);
        @(negedge clk); #1;
        hif.load  = 1'b1;
        hif.value = v;
        @(negedge clk); #1;
        hif.load  = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (hif.busy === 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("busy_timeout", {31'd0, hif.busy}, 32'd0);
    endtask

    task automatic wait_slot(input int k, input string name, input logic [6:0] exp);
        int n = 0;
        @(negedge clk);
        while (dut_an[k] !== 1'b0 && n < 16) begin
            @(negedge clk);
            n++;
        end
        check({name, "_anode"}, {31'd0, dut_an[k]}, 32'd0);
        check(name, {25'd0, dut_seg}, {25'd0, exp});
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        en        = 1'b0;
        hif.load  = 1'b0;
        hif.value = 10'd0;
        repeat (3) @(negedge clk);
        check("rst_an", {29'd0, dut_an}, 32'd7);
        check("rst_seg", {25'd0, dut_seg}, 32'h7F);
        #1 rst_n = 1'b1;
        en = 1'b1;
        repeat (14) @(negedge clk);
        wait_slot(0, "zero_units", 7'b1000000);
        wait_slot(1, "zero_tens_blank", 7'b1111111);
        wait_slot(2, "zero_hund_blank", 7'b1111111);

        // value 7: busy for exactly 11 cycles
        do_load(10'd7);
        n = 0;
        while (hif.busy === 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("busy_len", n, 32'd11);
        wait_slot(0, "seven_units", 7'b1111000);
        wait_slot(1, "seven_tens_blank", 7'b1111111);

        do_load(10'd305);
        wait_idle();
        wait_slot(2, "305_hund", 7'b0110000);
        wait_slot(1, "305_tens", 7'b1000000);
        wait_slot(0, "305_units", 7'b0010010);

        do_load(10'd1000);
        wait_idle();
        wait_slot(2, "ovf_hund", 7'b0111111);
        wait_slot(0, "ovf_units", 7'b0111111);

        do_load(10'd999);
        wait_idle();
        wait_slot(1, "999_tens", 7'b0010000);

        // second load 3 cycles into a conversion is dropped
        do_load(10'd42);
        repeat (2) @(negedge clk);
        #1 hif.load = 1'b1; hif.value = 10'd123;
        @(negedge clk); #1 hif.load = 1'b0;
        wait_idle();
        wait_slot(0, "42_units", 7'b0100100);
        wait_slot(1, "42_tens", 7'b0011001);

        // load held across the edge busy falls: taken one edge later
        do_load(10'd600);
        repeat (10) @(negedge clk);
        check("busy_before_fall", {31'd0, hif.busy}, 32'd1);
        #1 hif.load = 1'b1; hif.value = 10'd88;
        @(negedge clk);
        check("busy_fell", {31'd0, hif.busy}, 32'd0);
        @(negedge clk);
        check("busy_reaccept", {31'd0, hif.busy}, 32'd1);
        #1 hif.load = 1'b0;
        wait_idle();
        wait_slot(0, "88_units", 7'b0000000);

        // reset mid-conversion
        do_load(10'd512);
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_an", {29'd0, dut_an}, 32'd7);
        check("midrst_seg", {25'd0, dut_seg}, 32'h7F);
        check("midrst_busy", {31'd0, hif.busy}, 32'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        wait_slot(0, "postrst_units", 7'b1000000);

        // disabled display still converts
        #1 en = 1'b0;
        do_load(10'd321);
        wait_idle();
        @(negedge clk);
        check("dis_an", {29'd0, dut_an}, 32'd7);
        check("dis_seg", {25'd0, dut_seg}, 32'h7F);
        #1 en = 1'b1;
        @(negedge clk);
        check("reen_an0", {31'd0, an0}, 32'd0);
        check("reen_units", {25'd0, dut_seg}, {25'd0, 7'b1111001});
        wait_slot(2, "321_hund", 7'b0110000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream display stage for the CPU 4-bit result path, driving the 3-digit, active-low 7-segment board display (AN0..AN2, a..g/fp, dp).
- Captures a 10-bit binary value on a load strobe and converts it to 3 BCD digits with a sequential double-dabble.
- Time-multiplexes the digits with a prescaled refresh scan.
- Displayed digits change only on conversion commit, so the scan never shows a half-converted value.

Parameters:
- SCAN_DIV, 50000, clock cycles per digit slot; legal range ≥2.
- BLANK_LZ, 1, 1 = blank leading zeros in the hundreds and tens digits.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  1 = display on; 0 = all anodes off.
- load  in  1  single-cycle strobe that captures value; honoured only when busy=0.
- value  in  10  binary value to show; CPU drives {6'b0, rezult}.
- busy  out  1  conversion in progress.
- AN0, AN1, AN2  out  1 each  anodes, active low; AN0 = units, AN2 = hundreds.
- a, b, c, d, e, fp, g  out  1 each  segments, active low; fp is segment f.
- dp  out  1  decimal point, active low; held 1.

Behaviour:
Reset (asynchronous, reset_n=0):
- busy=0; AN0/AN1/AN2=1; all segments=1; dp=1.
- Committed digits = 0,0,0 and overflow flag = 0.
- Scan index=0, prescaler=0, converter in IDLE.
- Reset mid-conversion aborts it; nothing is committed.

Converter FSM (IDLE, SHIFT, COMMIT):
- IDLE→SHIFT on the edge where load=1 and busy=0. That edge captures value, clears the 12-bit BCD accumulator and sets the bit counter to 9. busy is 1 after the edge.
- SHIFT, one bit per cycle, MSB first:
  - Add 3 to every BCD nibble ≥5.
  - Shift {bcd, bin} left by one.
  - After the 10th shift, go to COMMIT.
- COMMIT (one cycle):
  - Write hundreds/tens/units to the display registers.
  - Overflow flag = (captured value > 999).
  - Go to IDLE; busy returns to 0.
- busy is high for exactly 11 cycles. The new digits are visible on the edge that ends COMMIT.
- load while busy=1 is ignored, not queued.
- load asserted on the same edge busy falls is ignored; it is accepted on the next edge.

Scan:
- Prescaler counts 0..SCAN_DIV-1 while enable=1.
- At terminal count: index advances 0→1→2→0 and prescaler wraps to 0.
- enable=0:
  - Prescaler and index held at 0.
  - All anodes=1; segments=1.
  - Conversion still runs and commits.
- Outputs are registered. Anode and segment pattern update on the same edge. Exactly one anode is low while enabled.
- Index mapping: 0 = AN0/units, 1 = AN1/tens, 2 = AN2/hundreds.

Segment rules:
- Standard hex-free 0–9 patterns, active low. Example: 0 → a–f=0, g=1; 1 → b,c=0.
- Overflow: every digit shows "-" (g=0, all others 1). Blanking does not apply.
- BLANK_LZ=1:
  - Hundreds is blank (all segments 1, anode still low) when it is 0.
  - Tens is blank when hundreds and tens are both 0.
  - Units is always shown.

Decomposition:
- Shared package/include holds:
  - Segment constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK (7-bit, {g,fp,e,d,c,b,a}, active low).
  - Converter state encodings ST_IDLE/ST_SHIFT/ST_COMMIT.
  - Digit index constants.
- One sub-module: bin2bcd_seq (10-bit → 3×4-bit sequential double-dabble with start/busy/done).
- The scan and segment logic stays in the top-level.

Test Plan (SCAN_DIV=4):
- Reset then enable=1, no load → index cycles every 4 clocks. AN0 low shows "0" (a–f=0, g=1). AN1/AN2 slots blank. dp=1 throughout.
- load with value=10'd7 → busy=1 for 11 cycles. Afterwards the AN0 slot shows 7 (a,b,c=0, rest 1); tens and hundreds blank.
- value=10'd305 → AN2=3, AN1=0 (not blanked, hundreds ≠0), AN0=5.
- value=10'd1000 → all three slots show "-" (g=0 only). value=10'd999 → 9,9,9.
- Second load 3 cycles into a conversion with a different value → ignored. busy still falls 11 cycles after the first load, and the first value is displayed.
- reset_n low 5 cycles into a conversion → all outputs return to reset values at once; after release, display shows units "0".
- enable=0 → AN0..AN2=1 and segments=1. A load still completes; after enable=1 the new value shows, starting at AN0.
